pa_add_val_gen: RTL and testbench
=================================

// Module: pa_add_val_gen
// PURPOSE
//  Upstream feeder of the PA counter wrapper. Per cycle, reduces per-channel transfer-length events
//  into one 16-bit add value per chain (8 channels/chain). Drives the pa10..pa13_add_val class of inputs.
//  Sums that exceed 16 bits are not dropped: the excess is carried in a per-chain residual and
//  drained on later cycles, so the counter total is exact unless the residual overflows.
// PARAMETERS
//  CH_NUM     16           number of DMA channels; multiple of 8
//  CHAIN_NUM  CH_NUM/8     number of chains; chain c owns channels 8c..8c+7
//  LEN_W      16           width of one event length
//  RES_W      20           residual accumulator width per chain; >= LEN_W+3
// PORTS
//  user_clk   in   1                   single clock domain
//  reset_n    in   1                   asynchronous, active-low reset
//  pa_enb     in   1                   1 = accept events; 0 = events masked to zero
//  pa_clr     in   1                   synchronous flush of pipeline, residual and ovf
//  ev_valid   in   CH_NUM              per-channel event strobe
//  ev_len     in   LEN_W x [CH_NUM]    per-channel length; ignored when ev_valid=0
//  add_val    out  16 x [CHAIN_NUM]    registered per-chain add value, one per cycle
//  ovf        out  CHAIN_NUM           sticky: chain residual saturated and counts were lost
// BEHAVIOUR
//  Reset (reset_n=0, async): all pipeline registers, residuals, add_val and ovf = 0.
//  S1 (capture): len_q[i] <= (ev_valid[i] & pa_enb) ? ev_len[i] : 0.
//  S2 (partial sums): per chain, two 4-channel sums (LEN_W+2 bits each), registered.
//  S3 (chain sum + drain): acc = res + psum0 + psum1, computed at RES_W+1 bits.
//  S3 outputs: add_val <= min(acc, 16'hFFFF); res <= acc - add_val_next.
//  S3 residual limit: if acc - 16'hFFFF > 2^RES_W-1, then res <= 2^RES_W-1 and ovf[c] <= 1.
//  ovf[c] is sticky until pa_clr or reset.
//  Latency: an event presented in cycle N appears in add_val at the end of cycle N+3
//  (visible in cycle N+3 after 3 clock edges).
//  Throughput: one event per channel per cycle, with no backpressure.
//  add_val is 0 in every cycle in which acc == 0.
//  pa_clr=1 (priority over all other inputs): next edge zeroes len_q, psums, res, add_val and ovf.
//  Events presented in the same cycle as pa_clr are discarded.
//  In-flight data and residual are lost on clear; this is intentional, as it matches the counter clear.
//  pa_enb=0: only new events are masked. Pipeline contents and residual continue to drain to add_val,
//  so counts accepted before disable are delivered.
//  Chains are fully independent; there is no cross-chain arithmetic.
//  Reset asserted mid-operation: immediate async clear; no partial values emitted after release.
//  All arithmetic is unsigned; no wrap-around anywhere (saturate only as above).
// STRUCTURE
//  Package pa_cnt_pkg holds:
//   - PA_VAL_W=16, CH_PER_CHAIN=8
//   - the default LEN_W / RES_W localparams
//   - function sat16(acc), returning the {add_val, residual} split
//  Sub-module pa_chain_sum holds S2+S3 for one chain: 8 lengths in -> add_val, ovf out.
//  pa_chain_sum is instantiated CHAIN_NUM times by generate.
//  S1 capture/mask stays in the top module.
// TESTING
//  1 Single event, ch3, len=100, pa_enb=1:
//    -> add_val[0]=100 for exactly one cycle at N+3, then 0; add_val[1]=0 throughout.
//  2 Residual drain, ch0..7 all len=0x4000 in one cycle (sum 0x20000):
//    -> add_val[0] = 0xFFFF, 0xFFFF, 0x0002 on 3 consecutive cycles, then 0; ovf[0]=0.
//  3 Chain isolation, ch8 len=5 and ch7 len=9 in the same cycle:
//    -> add_val[1]=5, add_val[0]=9 in the same output cycle.
//  4 Enable gating, ch0 len=50 at N, pa_enb=0 from N+1, ch0 len=70 at N+1:
//    -> add_val[0]=50 at N+3, nothing for the second event.
//  5 Clear mid-drain, do case 2, then pa_clr=1 on the cycle after the first 0xFFFF:
//    -> add_val[0]=0 from the next cycle on; no 0x0002 ever emitted; res=0.
//  6 Overflow, all ch0..7 len=0xFFFF on every cycle:
//    -> ovf[0] rises within 4 cycles, add_val[0] stays 0xFFFF;
//    -> after inputs stop and pa_clr=1: ovf[0]=0, add_val[0]=0.

Source files
------------

// File: rtl/pa_cnt_pkg.sv
// Shared widths and the add-value/residual split used by the PA add-value generator.
// Every chain output is clamped to PA_VAL_W bits, and any excess is carried forward to later cycles.
package pa_cnt_pkg;

  localparam int PA_VAL_W     = 16;
  localparam int CH_PER_CHAIN = 8;
  localparam int PA_LEN_W     = 16;
  localparam int PA_RES_W     = 20;

  typedef struct packed {
    logic [PA_VAL_W-1:0] val;
    logic [31:0]         rem;
  } pa_split_t;

  // Splits a chain accumulator into this cycle's add value and the part still owed.
  function automatic pa_split_t sat16(input logic [31:0] acc);
    pa_split_t s;
    if (acc > 32'(16'hFFFF)) begin
      s.val = 16'hFFFF;
      s.rem = acc - 32'(16'hFFFF);
    end else begin
      s.val = acc[PA_VAL_W-1:0];
      s.rem = '0;
    end
    return s;
  endfunction

endpackage

// File: rtl/pa_chain_sum.sv
// Partial-sum stage and the chain-sum/drain stage for one chain of eight channels.
// A sum that does not fit in 16 bits is held in a residual and paid out on later cycles.
module pa_chain_sum
  import pa_cnt_pkg::*;
#(
  parameter int LEN_W = PA_LEN_W,
  parameter int RES_W = PA_RES_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_clr,
  input  logic [CH_PER_CHAIN-1:0][LEN_W-1:0]  i_len,
  output logic [PA_VAL_W-1:0]                 o_add_val,
  output logic                                o_ovf
);

  localparam int PS_W  = LEN_W + 2;
  localparam int ACC_W = RES_W + 1;
  localparam logic [31:0] RES_MAX = (32'd1 << RES_W) - 32'd1;

  logic [PS_W-1:0]  w_psum0;
  logic [PS_W-1:0]  w_psum1;
  logic [PS_W-1:0]  r_psum0;
  logic [PS_W-1:0]  r_psum1;
  logic [RES_W-1:0] r_res;
  logic [ACC_W-1:0] w_acc;
  pa_split_t        w_split;
  logic             w_res_over;

  always_comb begin
    w_psum0 = '0;
    w_psum1 = '0;
    for (int k = 0; k < CH_PER_CHAIN / 2; k++) begin
      w_psum0 = w_psum0 + PS_W'(i_len[k]);
      w_psum1 = w_psum1 + PS_W'(i_len[k + CH_PER_CHAIN / 2]);
    end
  end

  // The accumulator is one bit wider than the residual, so the add cannot wrap.
  assign w_acc      = ACC_W'(r_res) + ACC_W'(r_psum0) + ACC_W'(r_psum1);
  assign w_split    = sat16(32'(w_acc));
  assign w_res_over = (w_split.rem > RES_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum0   <= '0;
      r_psum1   <= '0;
      r_res     <= '0;
      o_add_val <= '0;
      o_ovf     <= 1'b0;
    end else if (i_clr) begin
      r_psum0   <= '0;
      r_psum1   <= '0;
      r_res     <= '0;
      o_add_val <= '0;
      o_ovf     <= 1'b0;
    end else begin
      r_psum0   <= w_psum0;
      r_psum1   <= w_psum1;
      o_add_val <= w_split.val;
      if (w_res_over) begin
        r_res <= RES_W'(RES_MAX);
        o_ovf <= 1'b1;
      end else begin
        r_res <= w_split.rem[RES_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pa_add_val_gen.sv
// Reduces per-channel transfer-length events into one 16-bit add value per chain, three cycles later.
// Flow control: there is no valid/ready pair; every channel may strobe ev_valid each cycle and is always accepted.
module pa_add_val_gen
  import pa_cnt_pkg::*;
#(
  parameter int CH_NUM    = 16,
  parameter int CHAIN_NUM = CH_NUM / CH_PER_CHAIN,
  parameter int LEN_W     = PA_LEN_W,
  parameter int RES_W     = PA_RES_W
) (
  input  logic                                user_clk,
  input  logic                                reset_n,
  input  logic                                pa_enb,
  input  logic                                pa_clr,
  input  logic [CH_NUM-1:0]                   ev_valid,
  input  logic [CH_NUM-1:0][LEN_W-1:0]        ev_len,
  output logic [CHAIN_NUM-1:0][PA_VAL_W-1:0]  add_val,
  output logic [CHAIN_NUM-1:0]                ovf
);

  logic [CH_NUM-1:0][LEN_W-1:0] r_len_q;

  // Disabling masks only new events; anything already captured keeps draining.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len_q <= '0;
    end else if (pa_clr) begin
      r_len_q <= '0;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_len_q[i] <= (ev_valid[i] && pa_enb) ? ev_len[i] : '0;
      end
    end
  end

  for (genvar c = 0; c < CHAIN_NUM; c++) begin : g_chain
    pa_chain_sum #(
      .LEN_W (LEN_W),
      .RES_W (RES_W)
    ) u_chain_sum (
      .clk       (user_clk),
      .rst_n     (reset_n),
      .i_clr     (pa_clr),
      .i_len     (r_len_q[c*CH_PER_CHAIN +: CH_PER_CHAIN]),
      .o_add_val (add_val[c]),
      .o_ovf     (ovf[c])
    );
  end

endmodule

// File: tb/tb_pa_add_val_gen.sv
// Directed bench for pa_add_val_gen: a table of single-cycle vectors plus hand-written
// sequences for residual drain, enable gating, clear, overflow and asynchronous reset.
module tb_pa_add_val_gen;

  logic                   user_clk;
  logic                   reset_n;
  logic                   pa_enb;
  logic                   pa_clr;
  logic [15:0]            ev_valid;
  logic [15:0][15:0]      ev_len;
  logic [1:0][15:0]       add_val;
  logic [1:0]             ovf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string        name;
    logic [15:0]  valid;
    logic [15:0][15:0] len;
    logic         enb;
    logic [15:0]  exp0;
    logic [15:0]  exp1;
  } vec_t;

  vec_t vecs[7];

  pa_add_val_gen dut (
    .user_clk (user_clk),
    .reset_n  (reset_n),
    .pa_enb   (pa_enb),
    .pa_clr   (pa_clr),
    .ev_valid (ev_valid),
    .ev_len   (ev_len),
    .add_val  (add_val),
    .ovf      (ovf)
  );

  // clock / reset
  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  // driver tasks
  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic idle();
    ev_valid = '0;
    ev_len   = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_chain0_all(input logic [15:0] len);
    for (int i = 0; i < 8; i++) begin
      ev_valid[i] = 1'b1;
      ev_len[i]   = len;
    end
  endtask

  initial begin
    for (int i = 0; i < 7; i++) begin
      vecs[i].valid = '0;
      vecs[i].len   = '0;
      vecs[i].enb   = 1'b1;
    end
    vecs[0].name = "single_ch3";
    vecs[0].valid[3] = 1'b1; vecs[0].len[3] = 16'd100;
    vecs[0].exp0 = 16'd100; vecs[0].exp1 = 16'd0;
    vecs[1].name = "isolation";
    vecs[1].valid[8] = 1'b1; vecs[1].len[8] = 16'd5;
    vecs[1].valid[7] = 1'b1; vecs[1].len[7] = 16'd9;
    vecs[1].exp0 = 16'd9; vecs[1].exp1 = 16'd5;
    vecs[2].name = "chain0_all_1000";
    for (int i = 0; i < 8; i++) begin
      vecs[2].valid[i] = 1'b1; vecs[2].len[i] = 16'd1000;
    end
    vecs[2].valid[15] = 1'b1; vecs[2].len[15] = 16'hFFFF;
    vecs[2].exp0 = 16'd8000; vecs[2].exp1 = 16'hFFFF;
    vecs[3].name = "len_without_valid";
    vecs[3].len[2] = 16'd77; vecs[3].len[12] = 16'd33;
    vecs[3].exp0 = 16'd0; vecs[3].exp1 = 16'd0;
    vecs[4].name = "enb_low";
    vecs[4].valid = 16'hFFFF; vecs[4].len[0] = 16'd11; vecs[4].len[9] = 16'd22;
    vecs[4].enb = 1'b0;
    vecs[4].exp0 = 16'd0; vecs[4].exp1 = 16'd0;
    vecs[5].name = "exact_ffff";
    vecs[5].valid[0] = 1'b1; vecs[5].len[0] = 16'h8000;
    vecs[5].valid[1] = 1'b1; vecs[5].len[1] = 16'h7FFF;
    vecs[5].valid[9] = 1'b1; vecs[5].len[9] = 16'd1;
    vecs[5].valid[10] = 1'b1; vecs[5].len[10] = 16'd2;
    vecs[5].valid[11] = 1'b1; vecs[5].len[11] = 16'd3;
    vecs[5].exp0 = 16'hFFFF; vecs[5].exp1 = 16'd6;
    vecs[6].name = "upper_halves";
    for (int i = 4; i < 8; i++) begin
      vecs[6].valid[i] = 1'b1; vecs[6].len[i] = 16'h1111;
      vecs[6].valid[i+8] = 1'b1; vecs[6].len[i+8] = 16'h2222;
    end
    vecs[6].exp0 = 16'h4444; vecs[6].exp1 = 16'h8888;

    reset_n = 1'b0;
    pa_enb  = 1'b1;
    pa_clr  = 1'b0;
    idle();
    tick();
    tick();
    check("reset_add_val", 32'(add_val), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    tick();

    // table: each vector for one cycle, output three edges later, then back to zero
    for (int v = 0; v < 7; v++) begin
      ev_valid = vecs[v].valid;
      ev_len   = vecs[v].len;
      pa_enb   = vecs[v].enb;
      tick();
      idle();
      pa_enb = 1'b1;
      tick();
      check({vecs[v].name, "_pre0"}, 32'(add_val[0]), 32'd0);
      tick();
      check({vecs[v].name, "_ch0"}, 32'(add_val[0]), 32'(vecs[v].exp0));
      check({vecs[v].name, "_ch1"}, 32'(add_val[1]), 32'(vecs[v].exp1));
      tick();
      check({vecs[v].name, "_after0"}, 32'(add_val[0]), 32'd0);
      check({vecs[v].name, "_after1"}, 32'(add_val[1]), 32'd0);
    end

    // back-to-back events on consecutive cycles
    for (int k = 1; k <= 3; k++) begin
      ev_valid[0] = 1'b1; ev_len[0] = 16'(k);
      tick();
    end
    idle();
    for (int k = 1; k <= 3; k++) begin
      check("b2b_stream", 32'(add_val[0]), 32'(k));
      tick();
    end
    check("b2b_end", 32'(add_val[0]), 32'd0);

    // residual drain; disable right after capture, so the drain must continue regardless
    set_chain0_all(16'h4000);
    tick();
    pa_enb = 1'b0;
    tick();
    tick();
    check("drain_1", 32'(add_val[0]), 32'hFFFF);
    tick();
    check("drain_2", 32'(add_val[0]), 32'hFFFF);
    tick();
    check("drain_3", 32'(add_val[0]), 32'h0002);
    check("drain_ch1", 32'(add_val[1]), 32'd0);
    tick();
    check("drain_end", 32'(add_val[0]), 32'd0);
    check("drain_ovf", 32'(ovf), 32'd0);
    idle();
    pa_enb = 1'b1;
    tick();

    // enable gating: second event lands after disable
    ev_valid[0] = 1'b1; ev_len[0] = 16'd50;
    tick();
    pa_enb = 1'b0;
    ev_len[0] = 16'd70;
    tick();
    idle();
    tick();
    check("enb_first", 32'(add_val[0]), 32'd50);
    tick();
    check("enb_second", 32'(add_val[0]), 32'd0);
    tick();
    check("enb_second_late", 32'(add_val[0]), 32'd0);
    pa_enb = 1'b1;

    // clear mid-drain
    set_chain0_all(16'h4000);
    tick();
    idle();
    tick();
    tick();
    check("clr_first", 32'(add_val[0]), 32'hFFFF);
    tick();
    pa_clr = 1'b1;
    tick();
    pa_clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("clr_flushed", 32'(add_val[0]), 32'd0);
      tick();
    end

    // events in the same cycle as a clear are discarded
    ev_valid[3] = 1'b1; ev_len[3] = 16'd77;
    pa_clr = 1'b1;
    tick();
    pa_clr = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) begin
      check("clr_same_cycle", 32'(add_val[0]), 32'd0);
      tick();
    end

    // overflow: chain grows by 0x6FFF9 per cycle, residual exceeds 2^20-1 on the third sum
    set_chain0_all(16'hFFFF);
    for (int k = 0; k < 4; k++) tick();
    check("ovf_not_yet", 32'(ovf[0]), 32'd0);
    tick();
    check("ovf_set", 32'(ovf[0]), 32'd1);
    check("ovf_val", 32'(add_val[0]), 32'hFFFF);
    check("ovf_ch1", 32'(ovf[1]), 32'd0);
    tick();
    tick();
    idle();
    for (int k = 0; k < 4; k++) tick();
    check("ovf_sticky", 32'(ovf[0]), 32'd1);
    check("ovf_draining", 32'(add_val[0]), 32'hFFFF);
    pa_clr = 1'b1;
    tick();
    pa_clr = 1'b0;
    check("ovf_clr", 32'(ovf[0]), 32'd0);
    check("ovf_clr_val", 32'(add_val[0]), 32'd0);
    tick();
    check("ovf_clr_val2", 32'(add_val[0]), 32'd0);

    // asynchronous reset while data is in flight
    ev_valid[3] = 1'b1; ev_len[3] = 16'd100;
    tick();
    idle();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", 32'(add_val), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst", 32'(add_val[0]), 32'd0);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
